instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have one parameter: RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clock  in  1  sole clock; all state on rising edge
- reset  in  1  synchronous, active-high
- im_read  out  1  instruction-memory read request
- im_addr  out  32  instruction-memory byte address
- im_ready  in  1  read data valid this cycle (completes request)
- im_rdata  in  32  instruction word
- redirect  in  1  branch/jump taken; flush and refetch
- redirect_pc  in  32  new fetch address
- stall  in  1  decode stage not accepting this cycle
- ir_valid  out  1  ir/ir_pc hold a valid instruction
- ir  out  32  instruction at buffer head
- ir_pc  out  32  address of ir
- opcode  out  6  ir[30:25]
- sub_op_base  out  5  ir[4:0]
- sub_op_ls  out  8  ir[7:0]
- sub_op_j  out  1  ir[24]
- sub_op_jr  out  5  ir[4:0]
REQ-003 The clock SHALL be the only clock; reset SHALL be synchronous and active-high.

Function
REQ-004 State machine SHALL have states IDLE, FETCH, HOLD, DRAIN.
REQ-005 IDLE: entered on reset; next cycle unconditionally goes to FETCH with fetch_pc = RESET_PC.
REQ-006 FETCH: im_read=1, im_addr=fetch_pc; im_addr SHALL stay stable until im_ready.
REQ-007 On im_ready in FETCH without redirect: push {fetch_pc, im_rdata} into the 2-entry buffer; fetch_pc += 4 (mod 2^32); stay in FETCH if post-update count < 2, else go to HOLD.
REQ-008 HOLD: im_read=0; return to FETCH on the cycle after count drops below 2.
REQ-009 Buffer pop SHALL occur when ir_valid=1 and stall=0; push and pop in the same cycle leave count unchanged.
REQ-010 ir_valid = (count != 0); ir, ir_pc and all sub-fields SHALL be combinational from the buffer head.
REQ-011 redirect=1 SHALL empty the buffer in that cycle (no pop credited, ir_valid=0 the next cycle) and latch redirect_pc as fetch_pc.
REQ-012 redirect in FETCH with im_ready=0: go to DRAIN; DRAIN keeps im_read=1 with the old im_addr until im_ready, discards that data, then enters FETCH at the latched address.
REQ-013 redirect in the same cycle as im_ready: the response SHALL be discarded; next cycle FETCH at redirect_pc.
REQ-014 redirect in HOLD or IDLE: next cycle FETCH at redirect_pc.
REQ-015 A second redirect during DRAIN SHALL overwrite the latched address; the last one wins.
REQ-016 redirect_pc[1:0] SHALL be ignored (forced to 0).
REQ-017 At most one memory request SHALL be outstanding; count SHALL never exceed 2.

Reset
REQ-018 While reset=1: im_read=0, im_addr=RESET_PC, ir_valid=0, count=0, buffer contents and ir/ir_pc=0, state=IDLE.
REQ-019 Reset asserted mid-request or mid-DRAIN SHALL abandon the request without draining; reset has priority over redirect and im_ready.

Verification
REQ-020 Release reset, im_ready=1 every cycle, stall=0 -> im_addr 0,4,8,... on consecutive FETCH cycles; ir_pc tracks 0,4,8 with ir_valid=1 from the second cycle after the first request.
REQ-021 stall=1 held, im_ready=1 -> two pushes (pc 0,4), HOLD entered, im_read=0; deassert stall -> ir 0 then 4 delivered, fetch resumes at 8.
REQ-022 Request to 0x10 pending (im_ready=0), redirect to 0x100 -> im_addr stays 0x10 until im_ready, data dropped, next request at 0x100, ir_pc=0x100 first valid.
REQ-023 redirect to 0x200 coincident with im_ready for 0x20 -> 0x20 word never appears on ir; next im_addr=0x200.
REQ-024 fetch_pc=32'hFFFF_FFFC, im_ready=1 -> next im_addr=0x0000_0000.
REQ-025 ir=32'h4A12_3456 at head -> opcode=6'h25, sub_op_j=0, sub_op_base=5'h16, sub_op_ls=8'h56, sub_op_jr=5'h16.

Source files
------------

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Instruction fetch unit. It issues one read at a time to instruction memory
// and queues the returned words in a 2-entry buffer. The decode stage drains
// that buffer through ir/ir_pc. A taken branch (redirect) flushes the buffer
// and restarts fetching at the new address. If a read is still in flight
// when the redirect arrives, that read is finished and its data discarded.
//
// Ports
//   clock        sole clock, all state updates on the rising edge
//   reset        synchronous, active-high
//   im_read      instruction-memory read request
//   im_addr      instruction-memory byte address (held until im_ready)
//   im_ready     read data valid this cycle, completes the request
//   im_rdata     instruction word returned by memory
//   redirect     branch/jump taken: flush and refetch
//   redirect_pc  new fetch address (bits [1:0] ignored)
//   stall        decode stage not accepting this cycle
//   ir_valid     ir/ir_pc hold a valid instruction
//   ir, ir_pc    instruction at the buffer head and its address
//   opcode, sub_op_*  decoded fields of ir
// ---------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        im_read,
    output logic [31:0] im_addr,
    input  logic        im_ready,
    input  logic [31:0] im_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        ir_valid,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    output logic [5:0]  opcode,
    output logic [4:0]  sub_op_base,
    output logic [7:0]  sub_op_ls,
    output logic        sub_op_j,
    output logic [4:0]  sub_op_jr
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

    state_t      state_reg, state_next;
    logic [31:0] fetch_pc_reg, fetch_pc_next;
    logic [31:0] drain_addr_reg, drain_addr_next;   // address of the read being drained
    logic [1:0]  count_reg, count_next;
    logic        wr_ptr_reg, wr_ptr_next;
    logic        rd_ptr_reg, rd_ptr_next;

    logic [31:0] pc_mem   [2];
    logic [31:0] data_mem [2];

    logic [31:0] redirect_pc_aligned;
    logic        push;
    logic        pop;

    assign redirect_pc_aligned = {redirect_pc[31:2], 2'b00};

    // A redirect flushes the buffer. A response that lands in the same cycle
    // is not stored, and a head that leaves in the same cycle is not a pop.
    assign push = (state_reg == FETCH) && im_ready && !redirect;
    assign pop  = (count_reg != 2'd0) && !stall && !redirect;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= IDLE;
            fetch_pc_reg   <= RESET_PC;
            drain_addr_reg <= RESET_PC;
            count_reg      <= 2'd0;
            wr_ptr_reg     <= 1'b0;
            rd_ptr_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            fetch_pc_reg   <= fetch_pc_next;
            drain_addr_reg <= drain_addr_next;
            count_reg      <= count_next;
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
        end
    end

    // -----------------------------------------------------------------------
    // Buffer storage: one register pair per entry, written at the write pointer
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clock) begin
                if (reset) begin
                    pc_mem[gi]   <= 32'h0;
                    data_mem[gi] <= 32'h0;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    pc_mem[gi]   <= fetch_pc_reg;
                    data_mem[gi] <= im_rdata;
                end
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        fetch_pc_next   = fetch_pc_reg;
        drain_addr_next = drain_addr_reg;
        count_next      = count_reg + {1'b0, push} - {1'b0, pop};
        wr_ptr_next     = wr_ptr_reg ^ push;
        rd_ptr_next     = rd_ptr_reg ^ pop;

        if (redirect) begin
            count_next    = 2'd0;
            wr_ptr_next   = 1'b0;
            rd_ptr_next   = 1'b0;
            fetch_pc_next = redirect_pc_aligned;
        end

        case (state_reg)
            IDLE: begin
                state_next = FETCH;
            end
            FETCH: begin
                if (redirect) begin
                    // An accepted response is dropped on the spot. An
                    // outstanding one must still be waited out at its old address.
                    drain_addr_next = fetch_pc_reg;
                    state_next      = im_ready ? FETCH : DRAIN;
                end else if (im_ready) begin
                    fetch_pc_next = fetch_pc_reg + 32'd4;
                    if (count_next == 2'd2) begin
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect || (count_next != 2'd2)) begin
                    state_next = FETCH;
                end
            end
            DRAIN: begin
                // A redirect here has already overwritten fetch_pc; the last one wins.
                if (im_ready) begin
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs. Gating on reset keeps them at their reset values during the
    // first reset cycle, before the registers have been cleared.
    // -----------------------------------------------------------------------
    always_comb begin
        im_read  = 1'b0;
        im_addr  = RESET_PC;
        ir_valid = 1'b0;
        ir       = 32'h0;
        ir_pc    = 32'h0;
        if (!reset) begin
            im_read  = (state_reg == FETCH) || (state_reg == DRAIN);
            im_addr  = (state_reg == DRAIN) ? drain_addr_reg : fetch_pc_reg;
            ir_valid = (count_reg != 2'd0);
            ir       = data_mem[rd_ptr_reg];
            ir_pc    = pc_mem[rd_ptr_reg];
        end
    end

    assign opcode      = ir[30:25];
    assign sub_op_base = ir[4:0];
    assign sub_op_ls   = ir[7:0];
    assign sub_op_j    = ir[24];
    assign sub_op_jr   = ir[4:0];

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
// Directed testbench for instr_fetch. Each test lists, by hand, the
// addresses it expects decode to receive, and pushes them into a queue. A
// separate monitor process pops one entry from the queue each time the DUT
// hands over an instruction, and checks both the address and the word. The
// memory model returns the word pc + 0x1000_0000, or a fixed special word
// when that is enabled.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        im_read;
    logic [31:0] im_addr;
    logic        im_ready = 1'b0;
    logic [31:0] im_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall = 1'b0;
    logic        ir_valid;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic [5:0]  opcode;
    logic [4:0]  sub_op_base;
    logic [7:0]  sub_op_ls;
    logic        sub_op_j;
    logic [4:0]  sub_op_jr;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q [$];
    logic        special_en = 1'b0;

    localparam logic [31:0] SPECIAL_WORD = 32'h4A12_3456;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clock       (clock),
        .reset       (reset),
        .im_read     (im_read),
        .im_addr     (im_addr),
        .im_ready    (im_ready),
        .im_rdata    (im_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .ir_valid    (ir_valid),
        .ir          (ir),
        .ir_pc       (ir_pc),
        .opcode      (opcode),
        .sub_op_base (sub_op_base),
        .sub_op_ls   (sub_op_ls),
        .sub_op_j    (sub_op_j),
        .sub_op_jr   (sub_op_jr)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a + 32'h1000_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Inputs change just after the rising edge. The read data follows the
    // current address. The step returns at the falling edge, where outputs
    // are sampled.
    task automatic step(input logic rst, input logic rdy, input logic stl,
                        input logic rdr, input logic [31:0] rpc);
        @(posedge clock);
        #1;
        reset       = rst;
        im_ready    = rdy;
        stall       = stl;
        redirect    = rdr;
        redirect_pc = rpc;
        #1;
        im_rdata = special_en ? SPECIAL_WORD : mem_word(im_addr);
        @(negedge clock);
    endtask

    task automatic end_test(input string name);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk({name, "_rst_im_read"}, {31'h0, im_read}, 32'h0);
        chk({name, "_rst_ir_valid"}, {31'h0, ir_valid}, 32'h0);
        chk({name, "_queue_empty"}, exp_q.size(), 32'h0);
        exp_q.delete();
    endtask

    // Scoreboard monitor: one line per delivered instruction
    always @(negedge clock) begin
        logic [31:0] exp_pc;
        if (!reset && ir_valid && !stall && !redirect) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_delivery", ir_pc, 32'hxxxx_xxxx);
            end else begin
                exp_pc = exp_q.pop_front();
                chk("deliver_pc", ir_pc, exp_pc);
                chk("deliver_ir", ir, mem_word(exp_pc));
                $display("deliver pc=0x%08h ir=0x%08h (expected pc=0x%08h)", ir_pc, ir, exp_pc);
            end
        end
    end

    initial begin
        // ---------------- reset state ----------------
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("rst_im_read", {31'h0, im_read}, 32'h0);
        chk("rst_im_addr", im_addr, 32'h0);
        chk("rst_ir_valid", {31'h0, ir_valid}, 32'h0);
        chk("rst_ir", ir, 32'h0);
        chk("rst_ir_pc", ir_pc, 32'h0);

        // ---------------- streaming, no stall ----------------
        foreach (exp_q[i]) exp_q.delete(i);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        exp_q.push_back(32'hC);
        exp_q.push_back(32'h10);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("stream_idle_im_read", {31'h0, im_read}, 32'h0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
            chk("stream_im_addr", im_addr, 32'(4 * i));
            chk("stream_im_read", {31'h0, im_read}, 32'h1);
            if (i == 0) chk("stream_first_ir_valid", {31'h0, ir_valid}, 32'h0);
        end
        end_test("stream");

        // ---------------- stall fills buffer, HOLD ----------------
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);   // IDLE
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);   // FETCH 0
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);   // FETCH 4, buffer full
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);   // HOLD
        chk("hold_im_read", {31'h0, im_read}, 32'h0);
        chk("hold_ir_valid", {31'h0, ir_valid}, 32'h1);
        chk("hold_ir_pc", ir_pc, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);   // HOLD, pop 0
        chk("hold_pop_im_read", {31'h0, im_read}, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);   // FETCH 8, pop 4
        chk("resume_im_addr", im_addr, 32'h8);
        chk("resume_im_read", {31'h0, im_read}, 32'h1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        end_test("hold");

        // ---------------- redirect while request pending -> DRAIN ----------------
        exp_q.push_back(32'h100);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h10);  // IDLE + redirect
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);   // FETCH 0x10 pending
        chk("drain_req_addr", im_addr, 32'h10);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h200); // redirect, no ready
        chk("drain_redir_addr", im_addr, 32'h10);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h103); // DRAIN, second redirect wins
        chk("drain_hold_addr", im_addr, 32'h10);
        chk("drain_im_read", {31'h0, im_read}, 32'h1);
        chk("drain_ir_valid", {31'h0, ir_valid}, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);   // DRAIN completes, data dropped
        chk("drain_done_addr", im_addr, 32'h10);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);   // FETCH 0x100
        chk("drain_new_addr", im_addr, 32'h100);
        chk("drain_new_ir_valid", {31'h0, ir_valid}, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);   // deliver 0x100
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        end_test("drain");

        // ---------------- flush from HOLD, redirect with im_ready ----------------
        exp_q.push_back(32'h200);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);   // IDLE
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);   // FETCH 0
        chk("flush_start_addr", im_addr, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);   // FETCH 4 -> HOLD
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h20);  // HOLD + redirect flushes buffer
        chk("flush_hold_im_read", {31'h0, im_read}, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h200); // FETCH 0x20 + ready + redirect
        chk("coinc_addr", im_addr, 32'h20);
        chk("flush_ir_valid", {31'h0, ir_valid}, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);   // FETCH 0x200
        chk("coinc_next_addr", im_addr, 32'h200);
        chk("coinc_ir_valid", {31'h0, ir_valid}, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);   // deliver 0x200
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        end_test("coinc");

        // ---------------- address wrap ----------------
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("wrap_addr_top", im_addr, 32'hFFFF_FFFC);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("wrap_addr_zero", im_addr, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        end_test("wrap");

        // ---------------- field decode ----------------
        special_en = 1'b1;
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h40);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);   // FETCH 0x40, push special word
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("dec_ir", ir, 32'h4A12_3456);
        chk("dec_ir_pc", ir_pc, 32'h40);
        chk("dec_opcode", {26'h0, opcode}, 32'h25);
        chk("dec_sub_op_j", {31'h0, sub_op_j}, 32'h0);
        chk("dec_sub_op_base", {27'h0, sub_op_base}, 32'h16);
        chk("dec_sub_op_ls", {24'h0, sub_op_ls}, 32'h56);
        chk("dec_sub_op_jr", {27'h0, sub_op_jr}, 32'h16);
        special_en = 1'b0;
        end_test("decode");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
